// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core, external-requester and data-memory signals around the arbiter.
// slave: arbiter side; master: the surrounding core/requester/memory side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic              CpuMemWrite;
    logic              CpuMemRead;
    logic [ADDR_W-1:0] CpuAddr;
    logic [31:0]       CpuWData;
    logic [31:0]       CpuRData;
    logic              CpuStall;
    logic              ExtReq;
    logic              ExtWE;
    logic [ADDR_W-1:0] ExtAddr;
    logic [LEN_W-1:0]  ExtLen;
    logic [31:0]       ExtWData;
    logic              ExtAccept;
    logic              ExtBeat;
    logic              ExtDone;
    logic [31:0]       ExtRData;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData;

    modport slave (
        input  CpuMemWrite, CpuMemRead, CpuAddr, CpuWData,
        input  ExtReq, ExtWE, ExtAddr, ExtLen, ExtWData,
        input  MemRData,
        output CpuRData, CpuStall,
        output ExtAccept, ExtBeat, ExtDone, ExtRData,
        output MemWE, MemAddr, MemWData
    );

    modport master (
        output CpuMemWrite, CpuMemRead, CpuAddr, CpuWData,
        output ExtReq, ExtWE, ExtAddr, ExtLen, ExtWData,
        output MemRData,
        input  CpuRData, CpuStall,
        input  ExtAccept, ExtBeat, ExtDone, ExtRData,
        input  MemWE, MemAddr, MemWData
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Per-beat arbiter sharing the data-memory port between the core M stage and
// an external burst requester. Ports: CLK, Reset (sync, active-high), bus (slave).
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic CLK,
    input  logic Reset,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] beat_addr, beat_addr_nxt;
    logic [LEN_W-1:0]  beats_left, beats_left_nxt;
    logic              burst_we, burst_we_nxt;
    logic [7:0]        wait_cnt, wait_cnt_nxt;
    logic              cpu_acc;
    logic              ext_win;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            beat_addr  <= '0;
            beats_left <= '0;
            burst_we   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            beat_addr  <= beat_addr_nxt;
            beats_left <= beats_left_nxt;
            burst_we   <= burst_we_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    // A reset cycle is decoded as IDLE so an abandoned burst cannot
    // sneak one more write onto the port on the resetting edge.
    always_comb begin
        state_nxt      = state;
        beat_addr_nxt  = beat_addr;
        beats_left_nxt = beats_left;
        burst_we_nxt   = burst_we;
        wait_cnt_nxt   = wait_cnt;
        cpu_acc        = bus.CpuMemWrite | bus.CpuMemRead;
        ext_win        = 1'b0;
        bus.CpuStall   = 1'b0;
        bus.ExtAccept  = 1'b0;
        bus.ExtBeat    = 1'b0;
        bus.ExtDone    = 1'b0;
        bus.MemWE      = bus.CpuMemWrite;
        bus.MemAddr    = bus.CpuAddr;
        bus.MemWData   = bus.CpuWData;
        if (!Reset) begin
            unique case (state)
                IDLE: begin
                    bus.ExtAccept = bus.ExtReq;
                    if (bus.ExtReq) begin
                        beat_addr_nxt  = bus.ExtAddr;
                        beats_left_nxt = bus.ExtLen;
                        burst_we_nxt   = bus.ExtWE;
                        wait_cnt_nxt   = '0;
                        state_nxt      = BURST;
                    end
                end
                BURST: begin
                    ext_win = !cpu_acc || (wait_cnt == WAIT_LIM);
                    if (ext_win) begin
                        bus.MemAddr    = beat_addr;
                        bus.MemWE      = burst_we;
                        bus.MemWData   = bus.ExtWData;
                        bus.ExtBeat    = 1'b1;
                        bus.CpuStall   = cpu_acc;
                        beat_addr_nxt  = beat_addr + ADDR_W'(4);
                        wait_cnt_nxt   = '0;
                        beats_left_nxt = beats_left - LEN_W'(1);
                        if (beats_left == '0) begin
                            bus.ExtDone = 1'b1;
                            state_nxt   = IDLE;
                        end
                    end else if (wait_cnt != WAIT_LIM) begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.CpuRData = bus.MemRData;
    assign bus.ExtRData = bus.MemRData;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a queue-based reference model
// and a word-addressed data memory behind the port.
module tb_dmem_port_arbiter;
    localparam int MAXW = 8;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int checks = 0;
    int failures = 0;

    dmem_port_arbiter_if #(.ADDR_W(32), .LEN_W(4)) bus ();

    dmem_port_arbiter #(.ADDR_W(32), .LEN_W(4), .MAX_WAIT(MAXW)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:1023];
    logic mem_ready = 1'b0;

    assign bus.MemRData = mem[bus.MemAddr[11:2]];

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem_ready <= 1'b1;
        end else if (bus.MemWE) begin
            mem[bus.MemAddr[11:2]] <= bus.MemWData;
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: a pending burst is the list of addresses still to
    // be transferred; denied counts consecutive lost arbitrations.
    logic [31:0] q[$];
    logic m_we = 1'b0;
    int denied = 0;

    always @(negedge CLK) begin
        logic e_acc, e_beat, e_done, e_stall, e_we, cacc;
        logic [31:0] e_addr, e_wdata;
        cacc    = bus.CpuMemWrite | bus.CpuMemRead;
        e_acc   = 1'b0;
        e_beat  = 1'b0;
        e_done  = 1'b0;
        e_stall = 1'b0;
        e_we    = bus.CpuMemWrite;
        e_addr  = bus.CpuAddr;
        e_wdata = bus.CpuWData;
        if (!Reset && q.size() == 0) begin
            e_acc = bus.ExtReq;
        end else if (!Reset && (!cacc || denied == MAXW)) begin
            e_beat  = 1'b1;
            e_done  = (q.size() == 1);
            e_stall = cacc;
            e_we    = m_we;
            e_addr  = q[0];
            e_wdata = bus.ExtWData;
        end
        if (mem_ready) begin
            chk("m_accept", 64'(bus.ExtAccept), 64'(e_acc));
            chk("m_beat", 64'(bus.ExtBeat), 64'(e_beat));
            chk("m_done", 64'(bus.ExtDone), 64'(e_done));
            chk("m_stall", 64'(bus.CpuStall), 64'(e_stall));
            chk("m_we", 64'(bus.MemWE), 64'(e_we));
            chk("m_addr", 64'(bus.MemAddr), 64'(e_addr));
            chk("m_wdata", 64'(bus.MemWData), 64'(e_wdata));
            chk("m_cpu_rdata", 64'(bus.CpuRData), 64'(mem[e_addr[11:2]]));
            if (e_beat && !m_we)
                chk("m_ext_rdata", 64'(bus.ExtRData), 64'(mem[e_addr[11:2]]));
        end
        if (Reset) begin
            q.delete();
            denied = 0;
        end else if (q.size() == 0) begin
            if (bus.ExtReq) begin
                for (int k = 0; k <= int'(bus.ExtLen); k++)
                    q.push_back(bus.ExtAddr + 32'(4 * k));
                m_we = bus.ExtWE;
                denied = 0;
            end
        end else if (e_beat) begin
            void'(q.pop_front());
            denied = 0;
        end else if (denied < MAXW) begin
            denied++;
        end
    end

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic ext_req(logic we, logic [31:0] a, logic [3:0] len);
        bus.ExtReq  = 1'b1;
        bus.ExtWE   = we;
        bus.ExtAddr = a;
        bus.ExtLen  = len;
    endtask

    initial begin
        bus.CpuMemWrite = 0;
        bus.CpuMemRead  = 0;
        bus.CpuAddr     = 32'h0;
        bus.CpuWData    = 32'h0;
        bus.ExtReq      = 0;
        bus.ExtWE       = 0;
        bus.ExtAddr     = 32'h0;
        bus.ExtLen      = 4'h0;
        bus.ExtWData    = 32'h0;
        Reset = 1'b1;
        nxt();
        nxt();
        bus.CpuMemWrite = 1;
        bus.CpuAddr     = 32'h800;
        smp();
        chk("rst_memwe", 64'(bus.MemWE), 64'd1);
        chk("rst_stall", 64'(bus.CpuStall), 64'd0);
        chk("rst_accept", 64'(bus.ExtAccept), 64'd0);
        chk("rst_beat", 64'(bus.ExtBeat), 64'd0);
        nxt();
        Reset = 1'b0;
        bus.CpuMemWrite = 0;
        nxt();

        // write burst, idle core
        ext_req(1'b1, 32'h100, 4'd3);
        smp();
        chk("t1_accept", 64'(bus.ExtAccept), 64'd1);
        chk("t1_beat0", 64'(bus.ExtBeat), 64'd0);
        nxt();
        bus.ExtReq = 0;
        for (int i = 0; i < 4; i++) begin
            bus.ExtWData = 32'hA0 + 32'(i);
            smp();
            chk("t1_beat", 64'(bus.ExtBeat), 64'd1);
            chk("t1_addr", 64'(bus.MemAddr), 64'(32'h100 + 32'(4 * i)));
            chk("t1_done", 64'(bus.ExtDone), 64'(i == 3));
            chk("t1_stall", 64'(bus.CpuStall), 64'd0);
            nxt();
        end
        smp();
        for (int i = 0; i < 4; i++)
            chk("t1_mem", 64'(mem[32'h40 + 32'(i)]), 64'(32'hA0 + 32'(i)));
        nxt();

        // read burst against a core loading every cycle
        bus.CpuMemRead = 1;
        bus.CpuAddr    = 32'h300;
        ext_req(1'b0, 32'h200, 4'd1);
        smp();
        chk("t2_accept", 64'(bus.ExtAccept), 64'd1);
        nxt();
        bus.ExtReq = 0;
        for (int c = 1; c <= 18; c++) begin
            smp();
            chk("t2_beat", 64'(bus.ExtBeat), 64'(c == 9 || c == 18));
            chk("t2_stall", 64'(bus.CpuStall), 64'(c == 9 || c == 18));
            chk("t2_done", 64'(bus.ExtDone), 64'(c == 18));
            if (c == 9)
                chk("t2_rd0", 64'(bus.ExtRData), 64'h0000_0000_C0DE_0080);
            if (c == 18)
                chk("t2_rd1", 64'(bus.ExtRData), 64'h0000_0000_C0DE_0081);
            nxt();
        end
        bus.CpuMemRead = 0;

        // core store and forced ext write to the same word
        bus.CpuMemWrite = 1;
        bus.CpuAddr     = 32'h40;
        bus.CpuWData    = 32'h2222_2222;
        bus.ExtWData    = 32'h1111_1111;
        ext_req(1'b1, 32'h40, 4'd0);
        smp();
        chk("t3_accept", 64'(bus.ExtAccept), 64'd1);
        nxt();
        bus.ExtReq = 0;
        for (int c = 1; c <= 8; c++) begin
            smp();
            chk("t3_wait", 64'(bus.ExtBeat), 64'd0);
            nxt();
        end
        smp();
        chk("t3_beat", 64'(bus.ExtBeat), 64'd1);
        chk("t3_stall", 64'(bus.CpuStall), 64'd1);
        chk("t3_wdata", 64'(bus.MemWData), 64'h1111_1111);
        nxt();
        smp();
        chk("t3_mem_ext", 64'(mem[16]), 64'h1111_1111);
        chk("t3_retry", 64'(bus.CpuStall), 64'd0);
        chk("t3_cwdata", 64'(bus.MemWData), 64'h2222_2222);
        nxt();
        bus.CpuMemWrite = 0;
        smp();
        chk("t3_mem_cpu", 64'(mem[16]), 64'h2222_2222);
        nxt();

        // address wrap
        ext_req(1'b0, 32'hFFFF_FFFC, 4'd1);
        smp();
        chk("t4_accept", 64'(bus.ExtAccept), 64'd1);
        nxt();
        bus.ExtReq = 0;
        smp();
        chk("t4_addr0", 64'(bus.MemAddr), 64'hFFFF_FFFC);
        chk("t4_rd0", 64'(bus.ExtRData), 64'hC0DE_03FF);
        nxt();
        smp();
        chk("t4_addr1", 64'(bus.MemAddr), 64'h0);
        chk("t4_done", 64'(bus.ExtDone), 64'd1);
        chk("t4_rd1", 64'(bus.ExtRData), 64'hC0DE_0000);
        nxt();

        // reset mid-burst
        ext_req(1'b1, 32'h500, 4'd3);
        smp();
        nxt();
        bus.ExtReq = 0;
        bus.ExtWData = 32'hB0;
        smp();
        nxt();
        bus.ExtWData = 32'hB1;
        smp();
        nxt();
        bus.ExtWData = 32'hB2;
        Reset = 1'b1;
        smp();
        chk("t5_rst_we", 64'(bus.MemWE), 64'd0);
        chk("t5_rst_beat", 64'(bus.ExtBeat), 64'd0);
        chk("t5_rst_done", 64'(bus.ExtDone), 64'd0);
        nxt();
        Reset = 1'b0;
        smp();
        chk("t5_idle_we", 64'(bus.MemWE), 64'd0);
        chk("t5_idle_beat", 64'(bus.ExtBeat), 64'd0);
        chk("t5_mem0", 64'(mem[32'h140]), 64'hB0);
        chk("t5_mem1", 64'(mem[32'h141]), 64'hB1);
        chk("t5_mem2", 64'(mem[32'h142]), 64'hC0DE_0142);
        nxt();
        bus.CpuMemRead = 1;
        bus.CpuAddr    = 32'h300;
        ext_req(1'b0, 32'h600, 4'd0);
        smp();
        chk("t5_reaccept", 64'(bus.ExtAccept), 64'd1);
        nxt();
        bus.ExtReq = 0;
        for (int c = 1; c <= 9; c++) begin
            smp();
            chk("t5_wait_beat", 64'(bus.ExtBeat), 64'(c == 9));
            nxt();
        end
        bus.CpuMemRead = 0;

        // held request, single-beat bursts back to back
        ext_req(1'b0, 32'h700, 4'd0);
        for (int c = 0; c < 4; c++) begin
            smp();
            chk("t6_accept", 64'(bus.ExtAccept), 64'(c % 2 == 0));
            chk("t6_beat", 64'(bus.ExtBeat), 64'(c % 2 == 1));
            chk("t6_done", 64'(bus.ExtDone), 64'(c % 2 == 1));
            nxt();
        end
        bus.ExtReq = 0;
        smp();
        nxt();
        smp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the pipelined core's Memory stage and an external burst requester (program loader / debug port). It arbitrates per beat. The core wins by default. The external requester is guaranteed a beat after a bounded wait, and in that cycle the core receives a stall that the hazard unit uses to freeze the pipeline. It sits between the core's MemWrite/OpResult/WriteData/ReadData pins and the data memory, which has combinational read and writes on the clock edge.

## Interface
- ADDR_W, 32, address width; burst address wraps modulo 2^ADDR_W
- LEN_W, 4, burst length field width; beats = ExtLen+1 (1..16)
- MAX_WAIT, 8, number of consecutive denied external beats after which the external requester is forced through (1..255)

- CLK  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- CpuMemWrite  in  1  core M-stage store
- CpuMemRead  in  1  core M-stage load (MemtoRegM)
- CpuAddr  in  ADDR_W  core M-stage address (OpResultM)
- CpuWData  in  32  core store data
- CpuRData  out  32  load data to the core; equals MemRData
- CpuStall  out  1  core access is not performed this cycle; hold the M stage and everything upstream of it
- ExtReq  in  1  external burst request (level)
- ExtWE  in  1  1 = write burst, 0 = read burst; sampled at accept
- ExtAddr  in  ADDR_W  burst start address, word aligned; sampled at accept
- ExtLen  in  LEN_W  beats-1; sampled at accept
- ExtWData  in  32  write data for the current beat
- ExtAccept  out  1  request captured this cycle
- ExtBeat  out  1  one external beat is performed on the memory port this cycle
- ExtDone  out  1  last beat of the burst (coincides with ExtBeat)
- ExtRData  out  32  read beat data; valid when ExtBeat=1
- MemWE  out  1  memory write enable
- MemAddr  out  ADDR_W  memory address
- MemWData  out  32  memory write data
- MemRData  in  32  memory combinational read data

## Operation
- The FSM has two states: IDLE and BURST. Registers: BeatAddr, BeatsLeft (LEN_W bits), BurstWE, WaitCnt (8 bits).
- IDLE:
  - ExtAccept = ExtReq.
  - On accept, capture BeatAddr=ExtAddr, BeatsLeft=ExtLen, BurstWE=ExtWE, clear WaitCnt, and go to BURST.
  - No beat is performed in the accept cycle.
  - The core owns the port and CpuStall=0.
- BURST: compute CpuAcc = CpuMemWrite|CpuMemRead every cycle.
  - ExtWin = !CpuAcc or (WaitCnt == MAX_WAIT).
  - ExtWin=1:
    - Drive MemAddr=BeatAddr, MemWE=BurstWE, MemWData=ExtWData, and assert ExtBeat.
    - CpuStall = CpuAcc.
    - Next state: BeatAddr += 4 (wraps), WaitCnt=0, BeatsLeft -= 1.
    - If BeatsLeft was 0, assert ExtDone and go to IDLE.
  - ExtWin=0:
    - Drive MemAddr=CpuAddr, MemWE=CpuMemWrite, MemWData=CpuWData.
    - CpuStall=0 and ExtBeat=0.
    - WaitCnt += 1, saturating at MAX_WAIT.
- Outside BURST, or when the core wins, the port carries the core access. When there is no core access, MemWE=0 and MemAddr=CpuAddr.
- ExtRData = MemRData; the requester samples it when ExtBeat=1. CpuRData = MemRData; the core ignores it when CpuStall=1.
- ExtReq is ignored in BURST. A requester holding ExtReq after ExtDone gets a new accept in the following IDLE cycle.
- ExtWData must hold the current beat's data until ExtBeat is seen, then advance.
- Reset mid-burst: state returns to IDLE and the burst is abandoned. No ExtDone is issued and beats already written stay in memory.

## Timing
- Reset values:
  - State=IDLE; BeatAddr, BeatsLeft, BurstWE and WaitCnt all 0.
  - Outputs: CpuStall=0, ExtAccept=0 (while ExtReq=0), ExtBeat=0, ExtDone=0, MemWE=CpuMemWrite.
- All outputs are combinational from the current state plus this cycle's inputs, so there are zero-cycle decisions. The first external beat can occur one cycle after ExtAccept.
- Minimum burst duration is accept + (ExtLen+1) cycles. The worst case adds MAX_WAIT idle-for-ext cycles per beat.
- Core worst-case stall is 1 cycle per MAX_WAIT+1 cycles during a burst. The core is never stalled twice in a row unless MAX_WAIT=0, which is illegal.
- When a core load and a forced ext beat coincide, the core is stalled, then retries next cycle and wins, because WaitCnt=0.

## Test plan
- Idle core, ExtReq with ExtWE=1, ExtAddr=0x100, ExtLen=3, data 0xA0..0xA3:
  - ExtAccept at cycle 0; ExtBeat at cycles 1-4 with MemAddr 0x100/0x104/0x108/0x10C.
  - ExtDone at cycle 4; CpuStall never asserted.
- Read burst of 2 from 0x200 while the core loads every cycle, MAX_WAIT=8:
  - ExtBeat first occurs 9 cycles after accept, with CpuStall=1 in exactly that cycle.
  - The second beat follows 9 cycles later; ExtRData matches memory.
- Core store to 0x40 and ext write beat to 0x40 in the same forced cycle:
  - The ext write lands first; the core store is stalled, lands next cycle, and memory ends at the core value.
- ExtAddr=0xFFFFFFFC, ExtLen=1, idle core: beat addresses are 0xFFFFFFFC then 0x00000000.
- Reset asserted after the 2nd beat of a 4-beat write:
  - State returns to IDLE, with no ExtDone and no further MemWE.
  - The next ExtReq is accepted normally with WaitCnt=0.
- ExtReq held high across ExtDone with ExtLen=0:
  - Re-accepted in the cycle after ExtDone, giving an accept/beat/accept/beat pattern.
